pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, default 1024, the number of consecutive cycles without a hit that triggers a timeout (0 disables the timeout).
REQ-002 SHALL have port: CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ihit  input  1  instruction fetch complete this cycle.
REQ-005 SHALL have port: dhit  input  1  data access complete this cycle.
REQ-006 SHALL have port: dec_mem_rd  input  1  fetched instr is a load.
REQ-007 SHALL have port: dec_mem_wr  input  1  fetched instr is a store.
REQ-008 SHALL have port: dec_br_taken  input  1  fetched instr is a taken branch.
REQ-009 SHALL have port: dec_jump  input  1  fetched instr is J/JAL.
REQ-010 SHALL have port: dec_jr  input  1  fetched instr is JR.
REQ-011 SHALL have port: dec_halt  input  1  fetched instr is HALT.
REQ-012 SHALL have port: pc_en  output  1  PC register load enable.
REQ-013 SHALL have port: pc_sel  output  2  next-PC mux select: 00 PC+4, 01 branch target, 10 jump target, 11 register (JR).
REQ-014 SHALL have port: imemREN  output  1  instruction read request.
REQ-015 SHALL have port: dmemREN  output  1  data read request.
REQ-016 SHALL have port: dmemWEN  output  1  data write request.
REQ-017 SHALL have port: halt  output  1  processor halted (sticky).
REQ-018 SHALL have port: err  output  1  sequencing fault (sticky).
REQ-019 SHALL have port: state  output  2  FSM state: 00 IDLE, 01 IFETCH, 10 DACCESS, 11 HALTED.

Function
REQ-020 SHALL leave IDLE unconditionally for IFETCH after one cycle, with all request and enable outputs 0 in IDLE.
REQ-021 SHALL, in IFETCH, drive imemREN=1 and dmemREN=dmemWEN=0; with ihit=0, pc_en=0 and state held.
REQ-022 SHALL, in IFETCH with ihit=1, decode with priority halt > memory op > JR > jump > branch > sequential.
REQ-023 SHALL, on ihit with dec_halt=1, drive pc_en=0 and go to HALTED.
REQ-024 SHALL, on ihit with exactly one of dec_mem_rd/dec_mem_wr set, drive pc_en=0, latch the op type in a register, and go to DACCESS.
REQ-025 SHALL, on ihit with both dec_mem_rd and dec_mem_wr set, set err=1 and go to HALTED with pc_en=0.
REQ-026 SHALL, on ihit with no halt and no memory op, drive pc_en=1 in the same cycle (combinational) with pc_sel = 11 if dec_jr, else 10 if dec_jump, else 01 if dec_br_taken, else 00, and remain in IFETCH.
REQ-027 SHALL, in DACCESS, drive imemREN=0 and exactly one of dmemREN/dmemWEN per the latched op; while dhit=0, pc_en=0.
REQ-028 SHALL, in DACCESS with dhit=1, drive pc_en=1 and pc_sel=00 in the same cycle and go to IFETCH.
REQ-029 SHALL ignore dhit in IFETCH and ignore ihit in DACCESS.
REQ-030 SHALL, in HALTED, drive halt=1 and pc_en, imemREN, dmemREN, dmemWEN all 0, remaining there until reset.
REQ-031 SHALL keep pc_sel=00 whenever pc_en=0.
REQ-032 SHALL, while in IFETCH or DACCESS, increment a wait counter of width clog2(WAIT_LIMIT+1) on each cycle without the relevant hit, and clear it on a hit or any state change.
REQ-033 SHALL, when WAIT_LIMIT>0 and the missing-hit cycle would be the WAIT_LIMIT-th consecutive one, set err=1 and go to HALTED on the next edge with pc_en=0.
REQ-034 SHALL keep err sticky until reset.

Reset
REQ-035 SHALL, while nRST=0, asynchronously force state=IDLE, wait counter=0, latched op=0, err=0, halt=0, pc_en=0, pc_sel=00, imemREN=0, dmemREN=0, dmemWEN=0.
REQ-036 SHALL, on reset asserted mid-DACCESS, drop dmemREN/dmemWEN immediately and discard the latched op.

Verification
REQ-037 SHALL be verified by: release reset, ihit=1 with no dec_* -> state 00 then 01; pc_en=1, pc_sel=00 every cycle thereafter.
REQ-038 SHALL be verified by: ihit=1 with dec_mem_rd=1, dhit arriving 3 cycles later -> pc_en=0 for the fetch cycle plus 3 cycles, dmemREN=1 for 4 cycles, pc_en=1 with pc_sel=00 on the dhit cycle, then IFETCH.
REQ-039 SHALL be verified by: ihit=1 with dec_jr=1, dec_jump=1 and dec_br_taken=1 all set -> pc_sel=11 and pc_en=1.
REQ-040 SHALL be verified by: ihit=1 with dec_halt=1 and dec_mem_wr=1 both set -> pc_en=0, dmemWEN never asserted, halt=1 from the next cycle and held for 20 or more cycles.
REQ-041 SHALL be verified by: WAIT_LIMIT=4 with ihit held 0 in IFETCH -> err=1 and state=11 after the 4th missing cycle; with WAIT_LIMIT=0, no err after 5000 cycles.
REQ-042 SHALL be verified by: nRST pulsed low during DACCESS -> dmemREN=0 immediately, state=00, then IFETCH one cycle after release.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/data-access PC sequencer with hit timeout
module pc_sequencer #(
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       dec_mem_rd,
  input  logic       dec_mem_wr,
  input  logic       dec_br_taken,
  input  logic       dec_jump,
  input  logic       dec_jr,
  input  logic       dec_halt,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       imemREN,
  output logic       dmemREN,
  output logic       dmemWEN,
  output logic       halt,
  output logic       err,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] IFETCH  = 2'b01;
  localparam logic [1:0] DACCESS = 2'b10;
  localparam logic [1:0] HALTED  = 2'b11;

  // A zero limit still needs a one-bit counter so the logic stays well formed.
  localparam int unsigned CNT_W = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam bit TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             op_wr_q, op_wr_d;
  logic             err_q, err_d;
  logic             miss;
  logic             timeout;

  // A miss is a cycle spent waiting for the hit that the current state needs.
  always_comb begin
    miss    = ((state_q == IFETCH) && !ihit) || ((state_q == DACCESS) && !dhit);
    timeout = TIMEOUT_EN && miss && (wait_cnt_q == CNT_LAST);
  end

  // Next-state decode plus the combinational request/enable outputs.
  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    err_d    = err_q;
    pc_en    = 1'b0;
    pc_sel   = 2'b00;
    imemREN  = 1'b0;
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = IFETCH;
      end
      IFETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (dec_halt) begin
            state_d = HALTED;
          end else if (dec_mem_rd && dec_mem_wr) begin
            err_d   = 1'b1;
            state_d = HALTED;
          end else if (dec_mem_rd || dec_mem_wr) begin
            op_wr_d = dec_mem_wr;
            state_d = DACCESS;
          end else begin
            pc_en = 1'b1;
            if (dec_jr)            pc_sel = 2'b11;
            else if (dec_jump)     pc_sel = 2'b10;
            else if (dec_br_taken) pc_sel = 2'b01;
            else                   pc_sel = 2'b00;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = HALTED;
        end
      end
      DACCESS: begin
        dmemREN = !op_wr_q;
        dmemWEN = op_wr_q;
        if (dhit) begin
          pc_en   = 1'b1;
          state_d = IFETCH;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
    endcase
  end

  // Wait counter counts consecutive misses; any hit or state change clears it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!miss || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // State registers; reset is asynchronous so outputs drop the moment nRST falls.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      op_wr_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      op_wr_q    <= op_wr_d;
      err_q      <= err_d;
    end
  end

  assign halt  = (state_q == HALTED);
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int LIM = 4;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dec_mem_rd, dec_mem_wr, dec_br_taken, dec_jump, dec_jr, dec_halt;
  logic       pc_en, imemREN, dmemREN, dmemWEN, halt, err;
  logic [1:0] pc_sel, state;
  logic       n0_pc_en, n0_imemREN, n0_dmemREN, n0_dmemWEN, n0_halt, n0_err;
  logic [1:0] n0_pc_sel, n0_state;

  always #5 CLK = ~CLK;

  pc_sequencer #(.WAIT_LIMIT(LIM)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_br_taken(dec_br_taken),
    .dec_jump(dec_jump), .dec_jr(dec_jr), .dec_halt(dec_halt),
    .pc_en(pc_en), .pc_sel(pc_sel), .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .halt(halt), .err(err), .state(state)
  );

  pc_sequencer #(.WAIT_LIMIT(0)) u_nolim (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_br_taken(dec_br_taken),
    .dec_jump(dec_jump), .dec_jr(dec_jr), .dec_halt(dec_halt),
    .pc_en(n0_pc_en), .pc_sel(n0_pc_sel), .imemREN(n0_imemREN), .dmemREN(n0_dmemREN),
    .dmemWEN(n0_dmemWEN), .halt(n0_halt), .err(n0_err), .state(n0_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 fetching, 2 data access, 3 halted.
  int m_state = 0;
  bit m_wr    = 1'b0;
  int m_miss  = 0;
  bit m_err   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_outs();
    return {pc_en, pc_sel, imemREN, dmemREN, dmemWEN, halt, err, state};
  endfunction

  function automatic logic [9:0] model_out();
    logic       pe, im, dr, dw;
    logic [1:0] ps;
    pe = 1'b0; ps = 2'd0; im = 1'b0; dr = 1'b0; dw = 1'b0;
    if (m_state == 1) begin
      im = 1'b1;
      if (ihit && !dec_halt && !dec_mem_rd && !dec_mem_wr) begin
        pe = 1'b1;
        ps = dec_jr ? 2'd3 : dec_jump ? 2'd2 : dec_br_taken ? 2'd1 : 2'd0;
      end
    end else if (m_state == 2) begin
      dr = !m_wr;
      dw = m_wr;
      pe = dhit;
    end
    return {pe, ps, im, dr, dw, (m_state == 3), m_err, 2'(m_state)};
  endfunction

  task automatic model_step();
    bit hit;
    if (m_state == 0) begin
      m_state = 1;
      m_miss  = 0;
    end else if (m_state == 1 || m_state == 2) begin
      hit = (m_state == 1) ? ihit : dhit;
      if (hit) begin
        m_miss = 0;
        if (m_state == 2) m_state = 1;
        else if (dec_halt) m_state = 3;
        else if (dec_mem_rd && dec_mem_wr) begin m_err = 1'b1; m_state = 3; end
        else if (dec_mem_rd || dec_mem_wr) begin m_wr = dec_mem_wr; m_state = 2; end
      end else begin
        m_miss++;
        if (LIM > 0 && m_miss >= LIM) begin m_err = 1'b1; m_state = 3; m_miss = 0; end
      end
    end
  endtask

  task automatic clear_inputs();
    {ihit, dhit, dec_halt, dec_mem_rd, dec_mem_wr, dec_jr, dec_jump, dec_br_taken} = '0;
  endtask

  task automatic step_edge();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic tick(input string name);
    #2;
    chk(name, 32'(dut_outs()), 32'(model_out()));
    step_edge();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    #1;
    chk("reset_outs", 32'(dut_outs()), 32'd0);
    m_state = 0; m_miss = 0; m_err = 1'b0; m_wr = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  typedef struct packed {
    logic [7:0] in;
    logic       exp_pc_en;
    logic [1:0] exp_sel;
    logic [1:0] exp_next;
    logic       exp_err;
  } vec_t;

  vec_t vecs [0:12];

  initial begin
    int pe0, drn, dwn;
    // inputs: {ihit, dhit, halt, rd, wr, jr, jump, br}
    vecs[0]  = '{8'b0000_0000, 1'b0, 2'b00, 2'b01, 1'b0};
    vecs[1]  = '{8'b1000_0000, 1'b1, 2'b00, 2'b01, 1'b0};
    vecs[2]  = '{8'b1000_0001, 1'b1, 2'b01, 2'b01, 1'b0};
    vecs[3]  = '{8'b1000_0011, 1'b1, 2'b10, 2'b01, 1'b0};
    vecs[4]  = '{8'b1000_0111, 1'b1, 2'b11, 2'b01, 1'b0};
    vecs[5]  = '{8'b1001_0000, 1'b0, 2'b00, 2'b10, 1'b0};
    vecs[6]  = '{8'b1000_1100, 1'b0, 2'b00, 2'b10, 1'b0};
    vecs[7]  = '{8'b1010_1000, 1'b0, 2'b00, 2'b11, 1'b0};
    vecs[8]  = '{8'b1001_1000, 1'b0, 2'b00, 2'b11, 1'b1};
    vecs[9]  = '{8'b0101_0000, 1'b0, 2'b00, 2'b01, 1'b0};
    vecs[10] = '{8'b0010_0000, 1'b0, 2'b00, 2'b01, 1'b0};
    vecs[11] = '{8'b1010_0111, 1'b0, 2'b00, 2'b11, 1'b0};
    vecs[12] = '{8'b1000_0101, 1'b1, 2'b11, 2'b01, 1'b0};

    nRST = 1'b1;
    clear_inputs();
    #1;

    // Table: each vector applied in the first IFETCH cycle after reset.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      tick("vec_idle");
      {ihit, dhit, dec_halt, dec_mem_rd, dec_mem_wr, dec_jr, dec_jump, dec_br_taken} = vecs[i].in;
      #2;
      chk($sformatf("vec%0d_pc", i), 32'({pc_en, pc_sel}),
          32'({vecs[i].exp_pc_en, vecs[i].exp_sel}));
      step_edge();
      #1;
      chk($sformatf("vec%0d_next", i), 32'({state, err}),
          32'({vecs[i].exp_next, vecs[i].exp_err}));
    end

    // Straight-line fetch stream.
    do_reset();
    #2;
    chk("seq_idle_state", 32'(state), 32'd0);
    step_edge();
    ihit = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      chk("seq_fetch", 32'({state, pc_en, pc_sel}), 32'({2'b01, 1'b1, 2'b00}));
      step_edge();
    end

    // Load with dhit three cycles after the fetch.
    do_reset();
    tick("ld_idle");
    pe0 = 0; drn = 0; dwn = 0;
    for (int c = 0; c < 5; c++) begin
      ihit = 1'b1;
      dec_mem_rd = (c == 0);
      dhit = (c == 4);
      #2;
      if (!pc_en) pe0++;
      if (dmemREN) drn++;
      if (dmemWEN) dwn++;
      if (c == 4) chk("ld_dhit_pc", 32'({pc_en, pc_sel}), 32'({1'b1, 2'b00}));
      step_edge();
    end
    chk("ld_pc_en_low_cycles", 32'(pe0), 32'd4);
    chk("ld_dmemREN_cycles", 32'(drn), 32'd4);
    chk("ld_dmemWEN_cycles", 32'(dwn), 32'd0);
    clear_inputs();
    #1;
    chk("ld_back_to_fetch", 32'(state), 32'd1);

    // Halt beats a store; halted state is held regardless of inputs.
    do_reset();
    tick("halt_idle");
    ihit = 1'b1; dec_halt = 1'b1; dec_mem_wr = 1'b1;
    #2;
    chk("halt_fetch_cycle", 32'({pc_en, dmemWEN, halt}), 32'd0);
    step_edge();
    for (int c = 0; c < 25; c++) begin
      {ihit, dhit, dec_halt, dec_mem_rd, dec_mem_wr, dec_jr, dec_jump, dec_br_taken} = 8'($urandom);
      #2;
      chk("halt_held", 32'({halt, pc_en, imemREN, dmemREN, dmemWEN, err, state}),
          32'({1'b1, 5'b00000, 2'b11}));
      step_edge();
    end

    // Fetch timeout with WAIT_LIMIT=4; unlimited instance must never fault.
    do_reset();
    tick("to_idle");
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("to_waiting", 32'({state, err}), 32'({2'b01, 1'b0}));
      step_edge();
    end
    #1;
    chk("to_fault", 32'({state, err, pc_en}), 32'({2'b11, 1'b1, 1'b0}));
    repeat (5000) step_edge();
    chk("nolim_no_err", 32'({n0_err, n0_state}), 32'({1'b0, 2'b01}));

    // Asynchronous reset in the middle of a data access.
    do_reset();
    tick("ar_idle");
    ihit = 1'b1; dec_mem_rd = 1'b1;
    tick("ar_fetch");
    clear_inputs();
    #2;
    chk("ar_in_daccess", 32'({state, dmemREN}), 32'({2'b10, 1'b1}));
    nRST = 1'b0;
    #1;
    chk("ar_async_drop", 32'({state, dmemREN, dmemWEN}), 32'd0);
    m_state = 0; m_miss = 0; m_err = 1'b0; m_wr = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #2;
    chk("ar_idle_after", 32'(state), 32'd0);
    step_edge();
    #1;
    chk("ar_fetch_after", 32'(state), 32'd1);

    // Randomised traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((m_state == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) do_reset();
      ihit         = ($urandom_range(0, 3) != 0);
      dhit         = ($urandom_range(0, 3) != 0);
      dec_halt     = ($urandom_range(0, 49) == 0);
      dec_mem_rd   = ($urandom_range(0, 4) == 0);
      dec_mem_wr   = ($urandom_range(0, 4) == 0);
      dec_jr       = ($urandom_range(0, 2) == 0);
      dec_jump     = ($urandom_range(0, 2) == 0);
      dec_br_taken = ($urandom_range(0, 2) == 0);
      tick("rand_cycle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
